store_unit_ctrl: RTL and testbench

- Sequences one decoded RISC-V store (SB/SH/SW) from the decode stage into the data-memory write port.
- Computes the effective address, byte lanes and strobes. Splits word-crossing stores into two beats.
- Runs a valid/ready request handshake and waits for each write response. Reports completion or a fault to the pipeline control.
- Sits between the store decoder/register-file read and the data-memory interface. Holds the pipeline (st_ready low) while busy.

---
 rtl/store_unit_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_store_unit_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit_ctrl.sv
// ---------------------------------------------------------------------------
// store_unit_ctrl
//
// Takes one decoded RISC-V store (SB/SH/SW) from decode and turns it into
// one or two word-aligned writes on the data-memory port. It computes the
// effective address, aligns the strobes and data to the byte lanes, and
// splits a store that crosses a word boundary into two beats. It then waits
// for each write response and reports completion (done) or abort (fault).
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   st_valid/st_ready store command handshake (st_ready only in IDLE)
//   rs1_data, imm     base address and signed 12-bit offset
//   rs2_data          store data
//   store_control     funct3: 000 SB, 001 SH, 010 SW, others illegal
//   mem_req_*         write request (valid/ready) with addr, wdata, wstrb
//   mem_resp_valid    write response strobe, mem_resp_err its error flag
//   done, fault       one-cycle completion / abort pulses
//   fault_cause       1 illegal funct3, 2 bus error, 3 misaligned/timeout
//   busy              high whenever the controller is not idle
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. While valid is high and ready is low, the payload (operands on
// the command side, addr/wdata/wstrb on the memory side) is held stable.
// A response is sampled only in RESP0/RESP1, at the earliest one cycle after
// the request transfer.
// ---------------------------------------------------------------------------
module store_unit_ctrl #(
  parameter bit          SPLIT_MISALIGNED = 1'b1,
  parameter int unsigned MAX_WAIT         = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [11:0] imm,
  input  logic [2:0]  store_control,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic        mem_resp_err,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        busy
);

  localparam logic [16:0] MAX_WAIT_C = 17'(MAX_WAIT);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_BUS     = 2'd2;
  localparam logic [1:0] CAUSE_ALIGN   = 2'd3;  // also used for timeout

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ0   = 3'd1,
    S_RESP0  = 3'd2,
    S_REQ1   = 3'd3,
    S_RESP1  = 3'd4,
    S_REPORT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rpt_fault_q, rpt_fault_d;
  logic [1:0]  rpt_cause_q, rpt_cause_d;

  // Latched command: beat-0 word address plus the 8-lane strobe and
  // 64-bit data image spanning both possible beats.
  logic [29:0] waddr_q;
  logic [7:0]  strb_q;
  logic [63:0] data_q;

  // -------------------------------------------------------------------------
  // Command decode (from the live operands, used at the acceptance edge)
  // -------------------------------------------------------------------------
  logic [31:0] ea;
  logic [3:0]  size_mask;
  logic        legal;
  logic [7:0]  ext_strb;
  logic [63:0] ext_data;
  logic        crossing;

  always_comb begin
    ea        = rs1_data + {{20{imm[11]}}, imm};
    size_mask = 4'b0000;
    legal     = 1'b1;
    case (store_control)
      3'b000:  size_mask = 4'b0001;
      3'b001:  size_mask = 4'b0011;
      3'b010:  size_mask = 4'b1111;
      default: legal     = 1'b0;
    endcase
    ext_strb = {4'b0000, size_mask} << ea[1:0];
    ext_data = {32'h0000_0000, rs2_data} << {ea[1:0], 3'b000};
    // Any lane above byte 3 means the store spills into the next word.
    crossing = |ext_strb[7:4];
  end

  logic        accept;
  logic        has_beat1;
  logic [16:0] cnt_inc;
  logic        tmo;

  assign accept    = st_valid && (state_q == S_IDLE);
  assign has_beat1 = |strb_q[7:4];
  // 17 bits so the comparison cannot wrap when MAX_WAIT is 65535.
  assign cnt_inc   = {1'b0, cnt_q} + 17'd1;
  assign tmo       = (cnt_inc >= MAX_WAIT_C);

  // -------------------------------------------------------------------------
  // State register and latched command
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      rpt_fault_q <= 1'b0;
      rpt_cause_q <= CAUSE_NONE;
      waddr_q     <= 30'd0;
      strb_q      <= 8'd0;
      data_q      <= 64'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rpt_fault_q <= rpt_fault_d;
      rpt_cause_q <= rpt_cause_d;
      if (accept) begin
        waddr_q <= ea[31:2];
        strb_q  <= ext_strb;
        data_q  <= ext_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rpt_fault_d = rpt_fault_q;
    rpt_cause_d = rpt_cause_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (st_valid) begin
          if (!legal) begin
            state_d     = S_REPORT;
            rpt_fault_d = 1'b1;
            rpt_cause_d = CAUSE_ILLEGAL;
          end else if (crossing && !SPLIT_MISALIGNED) begin
            state_d     = S_REPORT;
            rpt_fault_d = 1'b1;
            rpt_cause_d = CAUSE_ALIGN;
          end else begin
            state_d     = S_REQ0;
            rpt_fault_d = 1'b0;
            rpt_cause_d = CAUSE_NONE;
          end
        end
      end

      // A request transfer in the timeout cycle still makes progress.
      S_REQ0, S_REQ1: begin
        cnt_d = cnt_inc[15:0];
        if (mem_req_ready) begin
          state_d = (state_q == S_REQ0) ? S_RESP0 : S_RESP1;
        end else if (tmo) begin
          state_d     = S_REPORT;
          rpt_fault_d = 1'b1;
          rpt_cause_d = CAUSE_ALIGN;
        end
      end

      // A response in the timeout cycle wins over the timeout.
      S_RESP0, S_RESP1: begin
        cnt_d = cnt_inc[15:0];
        if (mem_resp_valid) begin
          if (mem_resp_err) begin
            state_d     = S_REPORT;
            rpt_fault_d = 1'b1;
            rpt_cause_d = CAUSE_BUS;
          end else if ((state_q == S_RESP0) && has_beat1) begin
            state_d = S_REQ1;
            cnt_d   = 16'd0;
          end else begin
            state_d     = S_REPORT;
            rpt_fault_d = 1'b0;
            rpt_cause_d = CAUSE_NONE;
          end
        end else if (tmo) begin
          state_d     = S_REPORT;
          rpt_fault_d = 1'b1;
          rpt_cause_d = CAUSE_ALIGN;
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // -------------------------------------------------------------------------
  always_comb begin
    st_ready      = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    mem_req_valid = 1'b0;
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    mem_wstrb     = 4'd0;
    done          = 1'b0;
    fault         = 1'b0;
    fault_cause   = CAUSE_NONE;

    case (state_q)
      S_REQ0: begin
        mem_req_valid = 1'b1;
        mem_addr      = {waddr_q, 2'b00};
        mem_wdata     = data_q[31:0];
        mem_wstrb     = strb_q[3:0];
      end
      S_REQ1: begin
        // Second word wraps naturally at 2^32.
        mem_req_valid = 1'b1;
        mem_addr      = {waddr_q + 30'd1, 2'b00};
        mem_wdata     = data_q[63:32];
        mem_wstrb     = strb_q[7:4];
      end
      S_REPORT: begin
        done  = !rpt_fault_q;
        fault = rpt_fault_q;
        if (rpt_fault_q) begin
          fault_cause = rpt_cause_q;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_store_unit_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for store_unit_ctrl. Two instances: u_dut (split enabled, MAX_WAIT=4)
// carries most directed stores; u_ns (split disabled) checks the
// word-crossing fault path. Expected events carry the cycle they must appear
// in, so the scoreboard checks both content and latency.
// Event record: [85:84] kind (1 beat, 2 done, 3 fault), [83:68] cycle,
// [67:36] addr, [35:32] strb, [31:0] data (fault: cause in data).
// ---------------------------------------------------------------------------
module tb_store_unit_ctrl;
  localparam int W = 86;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st_valid, st_valid_ns;
  logic [31:0] rs1_data, rs2_data;
  logic [11:0] imm;
  logic [2:0]  store_control;
  logic        mem_req_ready, mem_resp_valid, mem_resp_err;

  logic        st_ready, mem_req_valid, done, fault, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  fault_cause;

  logic        st_ready_ns, mem_req_valid_ns, done_ns, fault_ns, busy_ns;
  logic [31:0] mem_addr_ns, mem_wdata_ns;
  logic [3:0]  mem_wstrb_ns;
  logic [1:0]  fault_cause_ns;

  store_unit_ctrl #(.SPLIT_MISALIGNED(1'b1), .MAX_WAIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .store_control(store_control), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_resp_err(mem_resp_err), .done(done), .fault(fault),
    .fault_cause(fault_cause), .busy(busy)
  );

  store_unit_ctrl #(.SPLIT_MISALIGNED(1'b0), .MAX_WAIT(4)) u_ns (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid_ns), .st_ready(st_ready_ns),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .store_control(store_control), .mem_req_valid(mem_req_valid_ns),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr_ns),
    .mem_wdata(mem_wdata_ns), .mem_wstrb(mem_wstrb_ns),
    .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err),
    .done(done_ns), .fault(fault_ns), .fault_cause(fault_cause_ns),
    .busy(busy_ns)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_ns_q[$];

  bit ready_en = 1'b1;
  bit resp_en = 1'b1;
  bit stray = 1'b0;
  bit pend = 1'b0;
  int err_beat = -1;
  int resp_idx = 0;
  int vcount = 0;

  assign mem_req_ready = ready_en;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- event constructors ----------------
  function automatic logic [W-1:0] ev_beat(input int c, input logic [31:0] a,
                                           input logic [3:0] s, input logic [31:0] d);
    return {2'd1, 16'(c), a, s, d};
  endfunction

  function automatic logic [W-1:0] ev_done(input int c);
    return {2'd2, 16'(c), 68'd0};
  endfunction

  function automatic logic [W-1:0] ev_fault(input int c, input logic [1:0] cause);
    return {2'd3, 16'(c), 36'd0, 30'd0, cause};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic score(input bit ns, input logic [W-1:0] got, input string nm);
    logic [W-1:0] e;
    bit empty;
    total++;
    empty = ns ? (exp_ns_q.size() == 0) : (exp_q.size() == 0);
    if (empty) begin
      bad++;
      $display("FAIL %s unexpected event: kind=%0d cyc=%0d addr=%h strb=%b data=%h",
               nm, got[85:84], got[83:68], got[67:36], got[35:32], got[31:0]);
    end else begin
      if (ns) e = exp_ns_q.pop_front();
      else    e = exp_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got kind=%0d cyc=%0d addr=%h strb=%b data=%h, want kind=%0d cyc=%0d addr=%h strb=%b data=%h",
                 nm, got[85:84], got[83:68], got[67:36], got[35:32], got[31:0],
                 e[85:84], e[83:68], e[67:36], e[35:32], e[31:0]);
      end
    end
  endtask

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req_valid) vcount++;
      if (mem_req_valid && mem_req_ready)
        score(1'b0, ev_beat(cyc, mem_addr, mem_wstrb, mem_wdata), "beat");
      if (done || fault) begin
        check("done_fault_exclusive", {done && fault, done ? fault_cause : 2'd0}, 128'd0);
        if (done) score(1'b0, ev_done(cyc), "done");
        else      score(1'b0, ev_fault(cyc, fault_cause), "fault");
      end
      if (mem_req_valid_ns && mem_req_ready)
        score(1'b1, ev_beat(cyc, mem_addr_ns, mem_wstrb_ns, mem_wdata_ns), "ns_beat");
      if (done_ns) score(1'b1, ev_done(cyc), "ns_done");
      if (fault_ns) score(1'b1, ev_fault(cyc, fault_cause_ns), "ns_fault");
    end
  end

  // ---------------- memory responder ----------------
  // Answers exactly one cycle after each request transfer of u_dut.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_err = 1'b0;
    end else begin
      mem_resp_valid = (pend && resp_en) || stray;
      mem_resp_err = pend && resp_en && (resp_idx == err_beat);
      if (pend && resp_en) resp_idx++;
      pend = mem_req_valid && mem_req_ready;
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with both controllers idle; acceptance is the next edge.
  task automatic issue(input bit ns, input logic [2:0] ctl, input logic [31:0] a,
                       input logic [11:0] im, input logic [31:0] d);
    rs1_data = a;
    imm = im;
    rs2_data = d;
    store_control = ctl;
    resp_idx = 0;
    vcount = 0;
    if (ns) st_valid_ns = 1'b1;
    else    st_valid = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    st_valid_ns = 1'b0;
  endtask

  task automatic finish_cmd(input string nm);
    int n;
    n = 0;
    while (!(st_ready && st_ready_ns) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_idle"}, {127'd0, n < 60}, 128'd1);
    check({nm, "_drained"}, 128'(exp_q.size() + exp_ns_q.size()), 128'd0);
    exp_q.delete();
    exp_ns_q.delete();
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    st_valid = 1'b0;
    st_valid_ns = 1'b0;
    rs1_data = '0;
    rs2_data = '0;
    imm = '0;
    store_control = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", {127'd0, st_ready}, 128'd1);
    check("rst_outputs", {mem_req_valid, mem_addr, mem_wdata, mem_wstrb, done, fault,
                          fault_cause, busy}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // SW aligned, one beat, done at accept+3
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF));
    exp_q.push_back(ev_done(a + 2));
    issue(1'b0, 3'b010, 32'h0000_1000, 12'h004, 32'hDEAD_BEEF);
    finish_cmd("sw");

    // SB with negative offset, top lane
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'h0000_1FFC, 4'b1000, 32'hAB00_0000));
    exp_q.push_back(ev_done(a + 2));
    issue(1'b0, 3'b000, 32'h0000_2000, 12'hFFF, 32'h0000_00AB);
    finish_cmd("sb_neg");

    // SH at offset 2, fits in one word
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'h0000_4000, 4'b1100, 32'h5678_0000));
    exp_q.push_back(ev_done(a + 2));
    issue(1'b0, 3'b001, 32'h0000_4000, 12'h002, 32'hFFFF_5678);
    finish_cmd("sh_off2");

    // SH crossing a word, two beats
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'h0000_3000, 4'b1000, 32'hEF00_0000));
    exp_q.push_back(ev_beat(a + 2, 32'h0000_3004, 4'b0001, 32'h0000_00CD));
    exp_q.push_back(ev_done(a + 4));
    issue(1'b0, 3'b001, 32'h0000_3000, 12'h003, 32'h0000_CDEF);
    finish_cmd("sh_split");

    // SW at offset 1, two beats
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'h0000_5000, 4'b1110, 32'h2233_4400));
    exp_q.push_back(ev_beat(a + 2, 32'h0000_5004, 4'b0001, 32'h0000_0011));
    exp_q.push_back(ev_done(a + 4));
    issue(1'b0, 3'b010, 32'h0000_5001, 12'h000, 32'h1122_3344);
    finish_cmd("sw_split");

    // SH crossing the top of the address space; beat 1 wraps to 0
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'hFFFF_FFFC, 4'b1000, 32'h3400_0000));
    exp_q.push_back(ev_beat(a + 2, 32'h0000_0000, 4'b0001, 32'h0000_0012));
    exp_q.push_back(ev_done(a + 4));
    issue(1'b0, 3'b001, 32'hFFFF_FFFF, 12'h000, 32'h0000_1234);
    finish_cmd("sh_wrap");

    // Illegal funct3: fault cause 1 right after acceptance, no request
    a = cyc + 1;
    exp_q.push_back(ev_fault(a, 2'd1));
    issue(1'b0, 3'b011, 32'h0000_6000, 12'h000, 32'h1234_5678);
    finish_cmd("illegal");

    // Bus error on beat 0 of a split store; beat 1 never issued
    err_beat = 0;
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'h0000_3000, 4'b1000, 32'hEF00_0000));
    exp_q.push_back(ev_fault(a + 2, 2'd2));
    issue(1'b0, 3'b001, 32'h0000_3000, 12'h003, 32'h0000_CDEF);
    finish_cmd("err_beat0");

    // Bus error on beat 1
    err_beat = 1;
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'h0000_3000, 4'b1000, 32'hEF00_0000));
    exp_q.push_back(ev_beat(a + 2, 32'h0000_3004, 4'b0001, 32'h0000_00CD));
    exp_q.push_back(ev_fault(a + 4, 2'd2));
    issue(1'b0, 3'b001, 32'h0000_3000, 12'h003, 32'h0000_CDEF);
    finish_cmd("err_beat1");
    err_beat = -1;

    // Split disabled: crossing SH faults with cause 3, no request
    a = cyc + 1;
    exp_ns_q.push_back(ev_fault(a, 2'd3));
    issue(1'b1, 3'b001, 32'h0000_3000, 12'h003, 32'h0000_CDEF);
    finish_cmd("ns_cross");

    // Request never accepted: valid for MAX_WAIT cycles, then timeout
    ready_en = 1'b0;
    a = cyc + 1;
    exp_q.push_back(ev_fault(a + 4, 2'd3));
    issue(1'b0, 3'b010, 32'h0000_7000, 12'h000, 32'h0BAD_F00D);
    finish_cmd("tmo_req");
    check("tmo_req_valid_cycles", 128'(vcount), 128'd4);
    ready_en = 1'b1;

    // Request accepted but response never arrives
    resp_en = 1'b0;
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'h0000_7000, 4'b1111, 32'h0BAD_F00D));
    exp_q.push_back(ev_fault(a + 4, 2'd3));
    issue(1'b0, 3'b010, 32'h0000_7000, 12'h000, 32'h0BAD_F00D);
    finish_cmd("tmo_resp");
    resp_en = 1'b1;

    // Reset in the middle of REQ0
    ready_en = 1'b0;
    issue(1'b0, 3'b010, 32'h0000_8000, 12'h000, 32'hCAFE_0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {mem_req_valid, mem_addr, mem_wdata, mem_wstrb, done, fault,
                             fault_cause, busy}, 128'd0);
    check("midrst_ready", {127'd0, st_ready}, 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ready_en = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {126'd0, st_ready, busy}, 128'd2);

    // Stray response while idle must be ignored
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    finish_cmd("stray");

    // Normal store after reset
    a = cyc + 1;
    exp_q.push_back(ev_beat(a, 32'h0000_9008, 4'b0100, 32'h005A_0000));
    exp_q.push_back(ev_done(a + 2));
    issue(1'b0, 3'b000, 32'h0000_9000, 12'h00A, 32'h0000_005A);
    finish_cmd("post_rst_sb");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
